// File: rtl/coin_sequencer.sv
// coin_sequencer
//   Sequences the coin-count datapath: queues dime/quarter insertions in a
//   small FIFO, issues them one per cycle to the external coin counter through
//   falling-edge (glitch-safe) enable/coin/reset lines, accumulates the
//   counter's dollar and nickel results into a vend credit and a nickel debt,
//   and drains both through req/ack handshakes.
//
// Ports
//   clk            single clock (FSM rising edge, counter drive falling edge)
//   reset          asynchronous active-low clear
//   dime_in        one-cycle pulse, dime inserted
//   quarter_in     one-cycle pulse, quarter inserted
//   service_clear  synchronous flush of FIFO, credit and nickel debt
//   coin_reject    one-cycle pulse, a coin was refused
//   cnt_enable     counter clock-gate enable (falling-edge register)
//   cnt_coin       coin type to the counter, 1 = dime (falling-edge register)
//   cnt_reset      active-low counter clear (falling-edge register)
//   cnt_dollar     counter dollar result for the coin being counted
//   cnt_nickel     counter nickel result for the coin being counted
//   vend_req/ack   product dispenser handshake
//   change_req/ack nickel hopper handshake
//   credit         current vend credit
//   nickel_owed    current nickel debt
//   busy           FIFO non-empty or coin in flight
module coin_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_CREDIT = 7,
  parameter int unsigned MAX_NICKEL = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dime_in,
  input  logic       quarter_in,
  input  logic       service_clear,
  output logic       coin_reject,
  output logic       cnt_enable,
  output logic       cnt_coin,
  output logic       cnt_reset,
  input  logic       cnt_dollar,
  input  logic       cnt_nickel,
  output logic       vend_req,
  input  logic       vend_ack,
  output logic       change_req,
  input  logic       change_ack,
  output logic [2:0] credit,
  output logic [2:0] nickel_owed,
  output logic       busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           count;

  logic issue_q;   // coin issued at the last edge, captured at the next one
  logic coin_q;    // type of the most recently issued coin
  logic clr_q;     // service_clear seen at the last edge

  logic [AW:0] free_slots;
  logic        take_dime;
  logic        take_quarter;
  logic        reject;
  logic        issue;
  logic        capture;
  logic        vend_fire;
  logic        change_fire;
  logic        credit_inc;
  logic        nickel_inc;

  always_comb begin
    free_slots   = DEPTH_V - count;
    // Dime has priority for the last free slot.
    take_dime    = dime_in && !service_clear && (free_slots != '0);
    take_quarter = quarter_in && !service_clear &&
                   (free_slots > {{AW{1'b0}}, take_dime});
    reject       = !service_clear &&
                   ((dime_in && !take_dime) || (quarter_in && !take_quarter));
    // The in-flight coin may still add one to either counter, so reserve
    // headroom for it before issuing another.
    issue        = (count != '0) && !service_clear &&
                   (({29'b0, credit} + {31'b0, issue_q}) < MAX_CREDIT) &&
                   (({29'b0, nickel_owed} + {31'b0, issue_q}) < MAX_NICKEL);
    capture      = cnt_enable && !service_clear;
    vend_fire    = vend_req && vend_ack;
    change_fire  = change_req && change_ack;
    credit_inc   = capture && cnt_dollar && (credit != 3'(MAX_CREDIT));
    nickel_inc   = capture && cnt_nickel && (nickel_owed != 3'(MAX_NICKEL));
  end

  assign busy = (count != '0) || issue_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_mem    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      issue_q     <= 1'b0;
      coin_q      <= 1'b0;
      clr_q       <= 1'b0;
      coin_reject <= 1'b0;
      credit      <= '0;
      nickel_owed <= '0;
      vend_req    <= 1'b0;
      change_req  <= 1'b0;
    end else begin
      coin_reject <= reject;
      if (service_clear) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        issue_q     <= 1'b0;
        clr_q       <= 1'b1;
        credit      <= '0;
        nickel_owed <= '0;
        vend_req    <= 1'b0;
        change_req  <= 1'b0;
      end else begin
        clr_q   <= 1'b0;
        issue_q <= issue;
        if (issue) begin
          coin_q <= fifo_mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        // Pushes only ever land in slots free before this edge's pop, so
        // they never collide with the entry being read.
        if (take_dime)
          fifo_mem[wr_ptr] <= 1'b1;
        if (take_quarter)
          fifo_mem[wr_ptr + AW'(take_dime)] <= 1'b0;
        wr_ptr <= wr_ptr + AW'(take_dime) + AW'(take_quarter);
        count  <= count + {{AW{1'b0}}, take_dime} + {{AW{1'b0}}, take_quarter}
                        - {{AW{1'b0}}, issue};

        unique case ({credit_inc, vend_fire})
          2'b10:   credit <= credit + 3'd1;
          2'b01:   credit <= credit - 3'd1;
          default: credit <= credit;
        endcase
        unique case ({nickel_inc, change_fire})
          2'b10:   nickel_owed <= nickel_owed + 3'd1;
          2'b01:   nickel_owed <= nickel_owed - 3'd1;
          default: nickel_owed <= nickel_owed;
        endcase

        // Req follows the pre-edge count, so it rises one cycle after the
        // count turns non-zero and sits low for one cycle after each ack.
        vend_req   <= !vend_fire && (credit != '0);
        change_req <= !change_fire && (nickel_owed != '0);
      end
    end
  end

  // Counter drive stage: retimed onto the falling edge so the counter's
  // gated clock never sees enable change while clk is high.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_enable <= 1'b0;
      cnt_coin   <= 1'b0;
      cnt_reset  <= 1'b0;
    end else begin
      cnt_enable <= issue_q;
      cnt_coin   <= coin_q;
      cnt_reset  <= !clr_q;
    end
  end

endmodule

// File: tb/tb_coin_sequencer.sv
module tb_coin_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dime_in = 1'b0;
  logic       quarter_in = 1'b0;
  logic       service_clear = 1'b0;
  logic       coin_reject;
  logic       cnt_enable;
  logic       cnt_coin;
  logic       cnt_reset;
  logic       cnt_dollar = 1'b0;
  logic       cnt_nickel = 1'b0;
  logic       vend_req;
  logic       vend_ack = 1'b0;
  logic       change_req;
  logic       change_ack = 1'b0;
  logic [2:0] credit;
  logic [2:0] nickel_owed;
  logic       busy;

  always #5 clk = ~clk;

  coin_sequencer #(
    .FIFO_DEPTH(4),
    .MAX_CREDIT(7),
    .MAX_NICKEL(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dime_in(dime_in),
    .quarter_in(quarter_in),
    .service_clear(service_clear),
    .coin_reject(coin_reject),
    .cnt_enable(cnt_enable),
    .cnt_coin(cnt_coin),
    .cnt_reset(cnt_reset),
    .cnt_dollar(cnt_dollar),
    .cnt_nickel(cnt_nickel),
    .vend_req(vend_req),
    .vend_ack(vend_ack),
    .change_req(change_req),
    .change_ack(change_ack),
    .credit(credit),
    .nickel_owed(nickel_owed),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: coin queue, integer counters, and a flag for the coin
  // currently handed to the counter.
  bit mq[$];
  int m_credit;
  int m_nick;
  bit m_inflight;
  bit m_coin;
  bit m_vreq;
  bit m_creq;
  bit m_rej;
  bit m_crst;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_credit = 0; m_nick = 0; m_inflight = 0; m_coin = 0;
    m_vreq = 0; m_creq = 0; m_rej = 0; m_crst = 0;
  endtask

  task automatic model_edge(input bit d, q, sc, va, ca, dol, nic);
    int  free, oldc, oldn;
    bit  cap, iss, vf, cf, td, tq;
    free = 4 - mq.size();
    oldc = m_credit;
    oldn = m_nick;
    cap  = m_inflight && !sc;
    iss  = (mq.size() > 0) && (oldc + m_inflight < 7) && (oldn + m_inflight < 7) && !sc;
    vf   = m_vreq && va;
    cf   = m_creq && ca;
    td   = d && !sc && free > 0;
    tq   = q && !sc && free > (td ? 1 : 0);
    m_rej  = !sc && ((d && !td) || (q && !tq));
    m_crst = !sc;
    if (sc) begin
      mq.delete();
      m_credit = 0; m_nick = 0; m_vreq = 0; m_creq = 0; m_inflight = 0;
    end else begin
      if (iss) m_coin = mq.pop_front();
      if (td) mq.push_back(1'b1);
      if (tq) mq.push_back(1'b0);
      m_credit = ((oldc + (cap && dol)) > 7 ? 7 : oldc + (cap && dol)) - vf;
      m_nick   = ((oldn + (cap && nic)) > 7 ? 7 : oldn + (cap && nic)) - cf;
      m_vreq = !vf && oldc > 0;
      m_creq = !cf && oldn > 0;
      m_inflight = iss;
    end
  endtask

  task automatic step(input bit d, q, sc, va, ca, dol, nic);
    dime_in = d; quarter_in = q; service_clear = sc;
    vend_ack = va; change_ack = ca; cnt_dollar = dol; cnt_nickel = nic;
    @(posedge clk);
    model_edge(d, q, sc, va, ca, dol, nic);
    #1;
    dime_in = 0; quarter_in = 0; service_clear = 0;
    check("coin_reject", 8'(coin_reject), 8'(m_rej));
    check("credit", 8'(credit), 8'(m_credit));
    check("nickel_owed", 8'(nickel_owed), 8'(m_nick));
    check("vend_req", 8'(vend_req), 8'(m_vreq));
    check("change_req", 8'(change_req), 8'(m_creq));
    check("busy", 8'(busy), 8'((mq.size() > 0) || m_inflight));
    @(negedge clk);
    #1;
    check("cnt_enable", 8'(cnt_enable), 8'(m_inflight));
    check("cnt_coin", 8'(cnt_coin), 8'(m_coin));
    check("cnt_reset", 8'(cnt_reset), 8'(m_crst));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cnt_enable"}, 8'(cnt_enable), 8'd0);
    check({tag, "_cnt_reset"}, 8'(cnt_reset), 8'd0);
    check({tag, "_cnt_coin"}, 8'(cnt_coin), 8'd0);
    check({tag, "_credit"}, 8'(credit), 8'd0);
    check({tag, "_nickel"}, 8'(nickel_owed), 8'd0);
    check({tag, "_vend_req"}, 8'(vend_req), 8'd0);
    check({tag, "_change_req"}, 8'(change_req), 8'd0);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_reject"}, 8'(coin_reject), 8'd0);
  endtask

  initial begin
    model_reset();
    // Power-on reset
    #2;
    check_cleared("por");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("por_cnt_reset_rise", 8'(cnt_reset), 8'd1);
    m_crst = 1;

    // Ten dimes back to back, occasional dollar, no acks
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, (i % 4) == 3, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

    // Drive credit up to the issue limit, then hammer the FIFO with pairs
    for (int i = 0; i < 30 && m_credit < 6; i++) step(mq.size() == 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, 0, 0);

    // Dollar and nickel on one capture with acks held high
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 1, 1);

    // Build credit 2, then capture a dollar while vend is acked
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0);

    // service_clear with coins queued; a dime in the clear cycle is dropped
    for (int i = 0; i < 8 && m_credit < 6; i++) step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset while a coin is enabled into the counter
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("pre_reset_cnt_enable", 8'(cnt_enable), 8'd1);
    reset = 1'b0;
    #1;
    check_cleared("midrst");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_cnt_reset_rise", 8'(cnt_reset), 8'd1);
    m_crst = 1;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
